// File: rtl/alu_pkg.sv
// ALU-side types shared with the status register.
package alu_pkg;

  typedef logic [3:0] alu_status_t;

endpackage

// File: rtl/reg_pkg.sv
// Register-file types: privilege mode and status word layout.
package reg_pkg;

  typedef enum logic {
    SUPERVISOR = 1'b0,
    USER       = 1'b1
  } cpu_mode_e;

  typedef struct packed {
    cpu_mode_e          mode;
    logic               imask;
    alu_pkg::alu_status_t alu_status;
  } status_t;

endpackage

// File: rtl/status_reg_pkg.sv
// Status register reset value and privilege-filtered full-word load.
package status_reg_pkg;

  import reg_pkg::*;

  localparam status_t STATUS_RST = '{
    mode:       SUPERVISOR,
    imask:      1'b1,
    alu_status: 4'b0000
  };

  // USER mode may only touch the flags through a full-word load.
  function automatic status_t full_load(
    input status_t cur,
    input status_t ld_val
  );
    status_t r;
    r = ld_val;
    if (cur.mode == USER) begin
      r.mode  = cur.mode;
      r.imask = cur.imask;
    end
    return r;
  endfunction

endpackage

// File: rtl/status_reg_if.sv
// Per-field load ports used by ALU, interrupt logic and control unit.
interface status_reg_if;

  import alu_pkg::*;
  import reg_pkg::*;

  alu_status_t alu_status_in;
  logic        ld_alu_status;
  logic        imask_in;
  logic        ld_imask;
  cpu_mode_e   mode_in;
  logic        ld_mode;

  modport master (
    output alu_status_in, ld_alu_status,
    output imask_in, ld_imask,
    output mode_in, ld_mode
  );

  modport slave (
    input alu_status_in, ld_alu_status,
    input imask_in, ld_imask,
    input mode_in, ld_mode
  );

endinterface

// File: rtl/status_reg.sv
// CPU status register: flags, imask, mode.
// Full-word access via two tri-state buses.
module status_reg
  import reg_pkg::*;
  import status_reg_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  status_t           in,
  input  logic              ld,
  input  logic              oe_a,
  input  logic              oe_b,
  output tri [5:0]          a,
  output tri [5:0]          b,
  status_reg_if.slave       fld,
  output status_t           value
);

  status_t status_q;
  status_t status_d;

  // Dedicated field loads win over the full-word load per field.
  always_comb begin
    status_d = status_q;
    if (ld) begin
      status_d = full_load(status_q, in);
    end
    if (fld.ld_alu_status) begin
      status_d.alu_status = fld.alu_status_in;
    end
    if (fld.ld_imask) begin
      status_d.imask = fld.imask_in;
    end
    if (fld.ld_mode) begin
      status_d.mode = fld.mode_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status_q <= STATUS_RST;
    end else begin
      status_q <= status_d;
    end
  end

  assign value = status_q;
  assign a = oe_a ? status_q : 6'bz;
  assign b = oe_b ? status_q : 6'bz;

endmodule

// File: tb/tb_status_reg.sv
// Scoreboard bench for status_reg.
// Idle buses are pulled up, so high-Z reads back as all ones.
module tb_status_reg;

  import reg_pkg::*;

  localparam logic [5:0] BUS_Z = 6'b111111;

  logic        clk;
  logic        rst;
  status_t     in;
  logic        ld;
  logic        oe_a;
  logic        oe_b;
  tri   [5:0]  a_bus;
  tri   [5:0]  b_bus;
  status_t     value;

  status_reg_if fld ();

  status_reg dut (
    .clk   (clk),
    .rst   (rst),
    .in    (in),
    .ld    (ld),
    .oe_a  (oe_a),
    .oe_b  (oe_b),
    .a     (a_bus),
    .b     (b_bus),
    .fld   (fld.slave),
    .value (value)
  );

  for (genvar i = 0; i < 6; i++) begin : g_pu
    pullup (a_bus[i]);
    pullup (b_bus[i]);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [5:0] val;
    logic [5:0] ea;
    logic [5:0] eb;
  } exp_t;

  exp_t sb[$];
  int   n_cmp;
  int   n_bad;

  task automatic chk(input string nm, input logic [5:0] act,
                     input logic [5:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.name, ".value"}, value, e.val);
      chk({e.name, ".a"}, a_bus, e.ea);
      chk({e.name, ".b"}, b_bus, e.eb);
    end
  end

  // Drive one cycle of loads, then enable buses and queue the expectation.
  task automatic step(
    input string      nm,
    input logic       r,
    input logic       l,
    input logic [5:0] w,
    input logic       la,
    input logic [3:0] av,
    input logic       li,
    input logic       iv,
    input logic       lm,
    input logic       mv,
    input logic       ea,
    input logic       eb,
    input logic [5:0] ev
  );
    exp_t e;
    rst                = r;
    ld                 = l;
    in                 = w;
    fld.ld_alu_status  = la;
    fld.alu_status_in  = av;
    fld.ld_imask       = li;
    fld.imask_in       = iv;
    fld.ld_mode        = lm;
    fld.mode_in        = cpu_mode_e'(mv);
    @(posedge clk);
    #1;
    rst               = 1'b0;
    ld                = 1'b0;
    fld.ld_alu_status = 1'b0;
    fld.ld_imask      = 1'b0;
    fld.ld_mode       = 1'b0;
    oe_a              = ea;
    oe_b              = eb;
    e.name = nm;
    e.val  = ev;
    e.ea   = ea ? ev : BUS_Z;
    e.eb   = eb ? ev : BUS_Z;
    sb.push_back(e);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1; ld = 1'b0; in = '0;
    oe_a = 1'b0; oe_b = 1'b0;
    fld.ld_alu_status = 1'b0; fld.alu_status_in = '0;
    fld.ld_imask = 1'b0; fld.imask_in = 1'b0;
    fld.ld_mode = 1'b0; fld.mode_in = SUPERVISOR;
    #2;
    //   name        rst ld in        la av      li iv lm mv oa ob expected
    step("reset",    1, 0, 6'b000000, 0, 4'h0, 0, 0, 0, 0, 0, 0, 6'b010000);
    step("mode_sv",  0, 0, 6'b000000, 0, 4'h0, 0, 0, 1, 0, 1, 1, 6'b010000);
    step("ld_2b",    0, 1, 6'b101011, 0, 4'h0, 0, 0, 0, 0, 1, 1, 6'b101011);
    step("ret_sv1",  0, 0, 6'b000000, 0, 4'h0, 0, 0, 1, 0, 1, 0, 6'b001011);
    step("ld_14",    0, 1, 6'b010100, 0, 4'h0, 0, 0, 0, 0, 1, 1, 6'b010100);
    step("ld_3f",    0, 1, 6'b111111, 0, 4'h0, 0, 0, 0, 0, 1, 1, 6'b111111);
    step("ret_sv2",  0, 0, 6'b000000, 0, 4'h0, 0, 0, 1, 0, 0, 1, 6'b011111);
    step("alu_f",    0, 0, 6'b000000, 1, 4'hf, 0, 0, 0, 0, 1, 1, 6'b011111);
    step("alu_a",    0, 0, 6'b000000, 1, 4'ha, 0, 0, 0, 0, 1, 1, 6'b011010);
    step("im_1",     0, 0, 6'b000000, 0, 4'h0, 1, 1, 0, 0, 1, 1, 6'b011010);
    step("im_0",     0, 0, 6'b000000, 0, 4'h0, 1, 0, 0, 0, 1, 1, 6'b001010);
    step("md_sv",    0, 0, 6'b000000, 0, 4'h0, 0, 0, 1, 0, 1, 1, 6'b001010);
    step("md_usr",   0, 0, 6'b000000, 0, 4'h0, 0, 0, 1, 1, 1, 1, 6'b101010);
    step("usr_im1",  0, 0, 6'b000000, 0, 4'h0, 1, 1, 0, 0, 1, 1, 6'b111010);
    step("usr_ld",   0, 1, 6'b001001, 0, 4'h0, 0, 0, 0, 0, 1, 1, 6'b111001);
    step("usr_trap", 0, 0, 6'b000000, 0, 4'h0, 0, 0, 1, 0, 1, 1, 6'b011001);
    step("sim_sv",   0, 1, 6'b000000, 1, 4'h6, 1, 1, 0, 0, 1, 1, 6'b010110);
    step("sim_md",   0, 1, 6'b000011, 0, 4'h0, 0, 0, 1, 1, 1, 1, 6'b100011);
    step("sim_usr",  0, 1, 6'b011111, 0, 4'h0, 1, 0, 0, 0, 1, 1, 6'b101111);
    step("rst_ld",   1, 1, 6'b111111, 0, 4'h0, 0, 0, 0, 0, 1, 1, 6'b010000);
    step("hold_a",   0, 0, 6'b101010, 0, 4'h0, 0, 0, 0, 0, 1, 0, 6'b010000);
    step("hold_b",   0, 0, 6'b101010, 0, 4'h0, 0, 0, 0, 0, 0, 1, 6'b010000);
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d left want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
